// File: rtl/tdm_demux_8.sv
// Purpose: serial-to-parallel TDM demux; one bit per accepted cycle is steered into 8 channel slots.
// Latency: y0..y7/frame_valid are registered on the edge that accepts the last bit of a frame.
// Backpressure: none; din_valid low simply stalls the slot sequence, with gaps of any length allowed.
// Optional feature: define TDM_DEMUX_PARITY_EN for a 9th even-parity bit per frame (PAR state).
module tdm_demux_8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       din_valid,
  input  logic       sync,
  output logic       y0,
  output logic       y1,
  output logic       y2,
  output logic       y3,
  output logic       y4,
  output logic       y5,
  output logic       y6,
  output logic       y7,
  output logic       frame_valid,
  output logic [2:0] slot,
  output logic       sync_err,
  output logic       parity_err
);

  // HUNT waits for the first sync, RUN collects data bits, PAR takes the parity bit.
`ifdef TDM_DEMUX_PARITY_EN
  typedef enum logic [1:0] {
    HUNT = 2'd0,
    RUN  = 2'd1,
    PAR  = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    HUNT = 2'd0,
    RUN  = 2'd1
  } state_t;
`endif

  state_t     state_q, state_d;
  logic [2:0] slot_q, slot_d;
  logic [7:0] shadow_q, shadow_d;  // partial frame being assembled
  logic [7:0] y_q, y_d;            // last good frame, bit N drives yN
  logic       frame_valid_q, frame_valid_d;
  logic       sync_err_q, sync_err_d;
`ifdef TDM_DEMUX_PARITY_EN
  logic       parity_err_q, parity_err_d;
`endif

  // Next-state and output computation; pulses default low so they last one cycle.
  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    shadow_d      = shadow_q;
    y_d           = y_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    parity_err_d  = 1'b0;
`endif
    if (din_valid) begin
      case (state_q)
        HUNT: begin
          // Unqualified bits are dropped until a sync marks slot 0.
          if (sync) begin
            shadow_d[0] = din;
            slot_d      = 3'd1;
            state_d     = RUN;
          end
        end
        RUN: begin
          if (sync && (slot_q != 3'd0)) begin
            // Sync mid-frame: drop the partial frame and restart with this bit as slot 0.
            sync_err_d  = 1'b1;
            shadow_d[0] = din;
            slot_d      = 3'd1;
          end else begin
            shadow_d[slot_q] = din;
            slot_d           = slot_q + 3'd1;  // wraps 7 -> 0
            if (slot_q == 3'd7) begin
`ifdef TDM_DEMUX_PARITY_EN
              state_d = PAR;
`else
              y_d           = {din, shadow_q[6:0]};
              frame_valid_d = 1'b1;
`endif
            end
          end
        end
`ifdef TDM_DEMUX_PARITY_EN
        PAR: begin
          if (sync) begin
            // Sync in the parity position is still mid-frame.
            sync_err_d  = 1'b1;
            shadow_d[0] = din;
            slot_d      = 3'd1;
          end else begin
            // Even parity: data bits plus the parity bit must XOR to zero.
            if ((^shadow_q ^ din) == 1'b0) begin
              y_d           = shadow_q;
              frame_valid_d = 1'b1;
            end else begin
              parity_err_d = 1'b1;
            end
            slot_d = 3'd0;
          end
          state_d = RUN;
        end
`endif
        default: begin
          state_d = HUNT;
          slot_d  = 3'd0;
        end
      endcase
    end
  end

  // State register with synchronous reset that overrides all inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HUNT;
      slot_q        <= 3'd0;
      shadow_q      <= 8'd0;
      y_q           <= 8'd0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      shadow_q      <= shadow_d;
      y_q           <= y_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  // Parity error pulse register.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign {y7, y6, y5, y4, y3, y2, y1, y0} = y_q;
  assign frame_valid = frame_valid_q;
  assign slot        = slot_q;
  assign sync_err    = sync_err_q;

endmodule
